// File: rtl/mc_pkg.sv
// Shared constants for the multicycle RV32I controller: state encoding,
// opcodes, ALUOp/ImmSrc codes and the ALU operation encoding.
package mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_JALRPC   = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_AUIPC    = 4'd14;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // R-type has no immediate; it shares the I encoding as a don't-care.
    function automatic logic [2:0] immSrcOf(input logic [6:0] op);
        case (op)
            OP_STORE:           return IMM_S;
            OP_BR:              return IMM_B;
            OP_JAL:             return IMM_J;
            OP_LUI, OP_AUIPC:   return IMM_U;
            default:            return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp plus the instruction funct fields onto an ALU
// operation code.
module aludec
    import mc_pkg::*;
(
    input  aluop_t      i_aluOp,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7b5,
    input  logic        i_op5,
    output logic [3:0]  o_aluControl
);

    // Only R-type (op[5]=1) can select sub; for I-type funct7b5 matters only for srai.
    always_comb begin
        o_aluControl = ALU_ADD;
        case (i_aluOp)
            ALUOP_ADD: o_aluControl = ALU_ADD;
            ALUOP_SUB: o_aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_aluControl = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_aluControl = ALU_SLL;
                    3'b010:  o_aluControl = ALU_SLT;
                    3'b011:  o_aluControl = ALU_SLTU;
                    3'b100:  o_aluControl = ALU_XOR;
                    3'b101:  o_aluControl = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_aluControl = ALU_OR;
                    default: o_aluControl = ALU_AND;
                endcase
            end
            default: o_aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the RV32I core on a single shared memory port,
// with a mem_req/mem_ready handshake that stalls fetch and data accesses.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        illegal_instr,
    output logic [3:0]  state_o
);

    logic [3:0] r_state;
    logic       r_illegal;
    logic [3:0] w_nextState;
    logic       w_setIllegal;
    logic       w_taken;
    aluop_t     w_aluOp;
    logic       w_irWrite;
    logic       w_pcWrite;
    logic       w_memWrite;
    logic       w_regWrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_setIllegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = !lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_nextState  = r_state;
        w_setIllegal = 1'b0;
        case (r_state)
            S_FETCH:    if (mem_ready) w_nextState = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_nextState = S_MEMADR;
                    OP_R:              w_nextState = S_EXECR;
                    OP_I:              w_nextState = S_EXECI;
                    OP_BR:             w_nextState = S_BRANCH;
                    OP_JAL:            w_nextState = S_JAL;
                    OP_JALR:           w_nextState = S_JALR;
                    OP_LUI:            w_nextState = S_LUI;
                    OP_AUIPC:          w_nextState = S_AUIPC;
                    default: begin
                        w_setIllegal = 1'b1;
                        w_nextState  = RESET_TRAP ? S_TRAP : S_FETCH;
                    end
                endcase
            end
            S_MEMADR:   w_nextState = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_nextState = S_MEMWB;
            S_MEMWB:    w_nextState = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_nextState = S_FETCH;
            S_EXECR:    w_nextState = S_ALUWB;
            S_EXECI:    w_nextState = S_ALUWB;
            S_ALUWB:    w_nextState = S_FETCH;
            S_BRANCH: begin
                w_nextState  = S_FETCH;
                w_setIllegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            S_JAL:      w_nextState = S_ALUWB;
            S_JALR:     w_nextState = S_JALRPC;
            S_JALRPC:   w_nextState = S_ALUWB;
            S_LUI:      w_nextState = S_ALUWB;
            S_AUIPC:    w_nextState = S_ALUWB;
            S_TRAP:     w_nextState = S_TRAP;
            default:    w_nextState = S_FETCH;
        endcase
    end

    // Moore decode; strobes go through w_* so they can be reset-gated below.
    always_comb begin
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        w_aluOp    = ALUOP_ADD;
        w_irWrite  = 1'b0;
        w_pcWrite  = 1'b0;
        w_memWrite = 1'b0;
        w_regWrite = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irWrite = mem_ready;
                w_pcWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regWrite = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                w_memWrite = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                w_aluOp = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_aluOp = ALUOP_FUNCT;
            end
            S_ALUWB:    w_regWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                w_aluOp   = ALUOP_SUB;
                w_pcWrite = w_taken;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_JALRPC: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcWrite = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Reset aborts an in-flight access at once, so no strobe can leak through.
    assign IRWrite       = w_irWrite  & rst_n;
    assign PCWrite       = w_pcWrite  & rst_n;
    assign MemWrite      = w_memWrite & rst_n;
    assign RegWrite      = w_regWrite & rst_n;
    assign ImmSrc        = immSrcOf(op);
    assign illegal_instr = r_illegal;
    assign state_o       = r_state;

    aludec u_aludec (
        .i_aluOp      (w_aluOp),
        .i_funct3     (funct3),
        .i_funct7b5   (funct7b5),
        .i_op5        (op[5]),
        .o_aluControl (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: each instruction is expanded into the
// list of cycles it should take, and every cycle's outputs are compared.
module tb_mc_controller;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = 7'b0110011;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        lt = 1'b0;
    logic        ltu = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        illegal_instr;
    logic [3:0]  state_o;

    typedef struct {
        logic [3:0] st;
        logic       mreq, adr, irw, pcw, mw, rw;
        logic [1:0] rs, a, b;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
        logic       rdy;
    } step_t;

    step_t      expQ[$];
    int         assertCount = 0;
    int         failCount = 0;
    int         rstStrobeCount = 0;
    logic       mIll = 1'b0;
    logic [2:0] curImm = 3'b000;

    always #5 clk = ~clk;

    mc_controller #(.RESET_TRAP(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .lt            (lt),
        .ltu           (ltu),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ImmSrc        (ImmSrc),
        .ALUControl    (ALUControl),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    // Any strobe seen while reset is held low is a leak.
    always @(MemWrite, IRWrite, PCWrite, RegWrite, rst_n) begin
        if (rst_n === 1'b0 && (MemWrite | IRWrite | PCWrite | RegWrite) === 1'b1) begin
            rstStrobeCount++;
        end
    end

    function automatic logic [2:0] immOf(input logic [6:0] o);
        if (o == OP_STORE) return 3'b001;
        if (o == OP_BR) return 3'b010;
        if (o == OP_JAL) return 3'b011;
        if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [3:0] expectAlu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0: return (o == OP_R && f7) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return f7 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic step_t mk(input logic [3:0] st);
        step_t s;
        s.st = st;  s.mreq = 1'b0; s.adr = 1'b0; s.irw = 1'b0; s.pcw = 1'b0;
        s.mw = 1'b0; s.rw = 1'b0; s.rs = 2'b00; s.a = 2'b00; s.b = 2'b00;
        s.imm = curImm; s.alu = ALU_ADD; s.ill = mIll;
        s.rdy = ($urandom_range(0, 1) == 1);
        return s;
    endfunction

    task automatic pushWb();
        step_t s;
        s = mk(S_ALUWB); s.rw = 1'b1; expQ.push_back(s);
    endtask

    // Expected cycle list for one instruction, from the instruction's own semantics.
    task automatic buildInstr(input logic [31:0] instr, input int fWait, input int mWait);
        step_t      s;
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;
        logic       taken;
        o = instr[6:0]; f3 = instr[14:12]; f7 = instr[30];
        curImm = immOf(o);
        for (int i = 0; i < fWait; i++) begin
            s = mk(S_FETCH); s.mreq = 1'b1; s.rs = 2'b10; s.b = 2'b10; s.rdy = 1'b0;
            expQ.push_back(s);
        end
        s = mk(S_FETCH); s.mreq = 1'b1; s.rs = 2'b10; s.b = 2'b10; s.rdy = 1'b1;
        s.irw = 1'b1; s.pcw = 1'b1; expQ.push_back(s);
        s = mk(S_DECODE); s.a = 2'b01; s.b = 2'b01; expQ.push_back(s);
        case (o)
            OP_LOAD, OP_STORE: begin
                s = mk(S_MEMADR); s.a = 2'b10; s.b = 2'b01; expQ.push_back(s);
                for (int i = 0; i <= mWait; i++) begin
                    s = mk((o == OP_LOAD) ? S_MEMREAD : S_MEMWRITE);
                    s.mreq = 1'b1; s.adr = 1'b1; s.rdy = (i == mWait);
                    s.mw = (o == OP_STORE) && (i == mWait);
                    expQ.push_back(s);
                end
                if (o == OP_LOAD) begin
                    s = mk(S_MEMWB); s.rs = 2'b01; s.rw = 1'b1; expQ.push_back(s);
                end
            end
            OP_R, OP_I: begin
                s = mk((o == OP_R) ? S_EXECR : S_EXECI);
                s.a = 2'b10; s.b = (o == OP_R) ? 2'b00 : 2'b01; s.alu = expectAlu(o, f3, f7);
                expQ.push_back(s);
                pushWb();
            end
            OP_BR: begin
                case (f3)
                    3'd0: taken = zero;
                    3'd1: taken = !zero;
                    3'd4: taken = lt;
                    3'd5: taken = !lt;
                    3'd6: taken = ltu;
                    3'd7: taken = !ltu;
                    default: taken = 1'b0;
                endcase
                s = mk(S_BRANCH); s.a = 2'b10; s.alu = ALU_SUB; s.pcw = taken;
                expQ.push_back(s);
                if (f3 == 3'd2 || f3 == 3'd3) mIll = 1'b1;
            end
            OP_JAL: begin
                s = mk(S_JAL); s.a = 2'b01; s.b = 2'b10; s.pcw = 1'b1; expQ.push_back(s);
                pushWb();
            end
            OP_JALR: begin
                s = mk(S_JALR); s.a = 2'b10; s.b = 2'b01; expQ.push_back(s);
                s = mk(S_JALRPC); s.a = 2'b01; s.b = 2'b10; s.pcw = 1'b1; expQ.push_back(s);
                pushWb();
            end
            OP_LUI: begin
                s = mk(S_LUI); s.a = 2'b11; s.b = 2'b01; expQ.push_back(s);
                pushWb();
            end
            OP_AUIPC: begin
                s = mk(S_AUIPC); s.a = 2'b01; s.b = 2'b01; expQ.push_back(s);
                pushWb();
            end
            default: mIll = 1'b1;
        endcase
    endtask

    task automatic checkOutput(input step_t s, input string tag);
        logic [23:0] obs;
        logic [23:0] exp;
        obs = {state_o, mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};
        exp = {s.st, s.mreq, s.adr, s.irw, s.pcw, s.mw, s.rw,
               s.rs, s.a, s.b, s.imm, s.alu, s.ill};
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed state=%0d vec=%h expected state=%0d vec=%h",
                   tag, state_o, obs, s.st, exp);
        end
    endtask

    task automatic runSteps(input string name, input int keep);
        step_t s;
        int    idx = 0;
        while (expQ.size() > keep) begin
            s = expQ.pop_front();
            mem_ready = s.rdy;
            @(negedge clk);
            checkOutput(s, $sformatf("%s cyc%0d", name, idx));
            idx++;
            @(posedge clk);
            #1;
        end
        expQ.delete();
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] instr, input int fWait,
                                 input int mWait, input logic zf, input logic ltf, input logic ltuf);
        op = instr[6:0]; funct3 = instr[14:12]; funct7b5 = instr[30];
        zero = zf; lt = ltf; ltu = ltuf;
        buildInstr(instr, fWait, mWait);
        runSteps(name, 0);
    endtask

    task automatic doReset(input string tag);
        step_t s;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mIll = 1'b0;
        curImm = immOf(op);
        s = mk(S_FETCH); s.mreq = 1'b1; s.rs = 2'b10; s.b = 2'b10;
        @(negedge clk);
        checkOutput(s, tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] instr;
        logic [6:0]  ops [9];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        $display("[TB] start");
        doReset("reset");

        applyStimulus("add", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus("lw_wait2", 32'h0000A183, 0, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus("bne_taken", 32'h00209463, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus("bne_nottaken", 32'h00209463, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus("jalr", 32'h000080E7, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus("sub", 32'h402081B3, 1, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus("srai", 32'h4020D193, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            instr = $urandom;
            instr[6:0] = ops[$urandom_range(0, 8)];
            applyStimulus($sformatf("rand%0d", n), instr, $urandom_range(0, 2), $urandom_range(0, 3),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 1) == 1));
        end

        // Store stalled in S_MEMWRITE, then reset lands while mem_ready rises.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        buildInstr(32'h0020A023, 0, 5);
        runSteps("sw_stall", 4);
        doReset("reset_in_memwrite");
        applyStimulus("add_after_rst", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);

        op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
        buildInstr(32'h00000000, 0, 0);
        for (int i = 0; i < 12; i++) expQ.push_back(mk(S_TRAP));
        runSteps("trap", 0);
        doReset("reset_from_trap");
        applyStimulus("lui_after_trap", 32'h123451B7, 0, 0, 1'b0, 1'b0, 1'b0);

        assertCount++;
        assert (rstStrobeCount === 0) else begin
            failCount++;
            $error("[TB] FAIL strobe_under_reset: observed %0d pulses, expected 0", rstStrobeCount);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the RV32I core. Sequences a shared-memory datapath (PC, OldPC, IR, A/B, ALUOut and Data registers) through fetch, decode, execute, memory and writeback.
- Replaces the single-cycle decoder when the core runs on one unified memory port.
- Adds a `mem_req`/`mem_ready` handshake so memory wait states stall the FSM.

Parameters:
- RESET_TRAP, 0, when 1 an illegal opcode parks the FSM in S_TRAP. When 0 the illegal opcode is treated as a NOP and the FSM returns to S_FETCH.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- op  input  7  IR[6:0]
- funct3  input  3  IR[14:12]
- funct7b5  input  1  IR[30]
- zero  input  1  ALU result == 0
- lt  input  1  signed rs1 < rs2
- ltu  input  1  unsigned rs1 < rs2
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access requested
- AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
- MemWrite  output  1  store strobe
- IRWrite  output  1  load IR and OldPC
- PCWrite  output  1  load PC from Result
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALU result
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  output  2  00 = rs2, 01 = imm, 10 = constant 4
- ImmSrc  output  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUControl  output  4  ALU operation
- illegal_instr  output  1  sticky flag, set on an undecodable opcode
- state_o  output  4  current state, for debug

Behaviour:
- Reset: asynchronous on `rst_n` low. State becomes S_FETCH and `illegal_instr` clears to 0.
- Outputs are a Moore decode of state, except that the handshake-gated strobes (`IRWrite`, `PCWrite`, `MemWrite`) also depend on `mem_ready`. Under reset: `mem_req` = 1, and every gated strobe, `RegWrite` and `illegal_instr` = 0.
- Unlisted outputs are 0 in every state. `ImmSrc` is decoded combinationally from `op` in all states.
- ALUOp is internal: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- States and actions:
  - S_FETCH: `mem_req`=1, `AdrSrc`=0, A=00, B=10, ALUOp=00, `ResultSrc`=10. `IRWrite` and `PCWrite` = `mem_ready`. Stays in S_FETCH while `mem_ready`=0; goes to S_DECODE when `mem_ready`=1.
  - S_DECODE: A=01, B=01, ALUOp=00 (precomputes branch/jal target).
    - Next state by op: load/store -> S_MEMADR, R-type -> S_EXECR, I-ALU -> S_EXECI, branch -> S_BRANCH, jal -> S_JAL, jalr -> S_JALR.
    - lui -> S_LUI, auipc -> S_AUIPC.
    - Any other op -> S_TRAP, or S_FETCH when RESET_TRAP=0. Either way `illegal_instr` is set.
  - S_MEMADR: A=10, B=01, ALUOp=00. Goes to S_MEMREAD if op=load, else S_MEMWRITE.
  - S_MEMREAD: `mem_req`=1, `AdrSrc`=1. Holds until `mem_ready`, then goes to S_MEMWB.
  - S_MEMWB: `ResultSrc`=01, `RegWrite`=1. Goes to S_FETCH.
  - S_MEMWRITE: `mem_req`=1, `AdrSrc`=1, `MemWrite`=`mem_ready`. Holds until `mem_ready`, then goes to S_FETCH.
  - S_EXECR: A=10, B=00, ALUOp=10. Goes to S_ALUWB.
  - S_EXECI: A=10, B=01, ALUOp=10. Goes to S_ALUWB.
  - S_ALUWB: `ResultSrc`=00, `RegWrite`=1. Goes to S_FETCH.
  - S_BRANCH: A=10, B=00, ALUOp=01, `ResultSrc`=00, `PCWrite`=taken. Goes to S_FETCH.
    - taken by funct3: 000 = zero, 001 = !zero, 100 = lt, 101 = !lt, 110 = ltu, 111 = !ltu.
    - funct3 010 or 011: taken = 0, `illegal_instr` set.
  - S_JAL: A=01, B=10, ALUOp=00, `ResultSrc`=00, `PCWrite`=1. Goes to S_ALUWB (rd <- OldPC+4).
  - S_JALR: A=10, B=01, ALUOp=00. Goes to S_JALRPC.
  - S_JALRPC: `ResultSrc`=00, `PCWrite`=1, A=01, B=10, ALUOp=00. Goes to S_ALUWB.
  - S_LUI: A=11, B=01, ALUOp=00. Goes to S_ALUWB.
  - S_AUIPC: A=01, B=01, ALUOp=00. Goes to S_ALUWB.
  - S_TRAP: all strobes 0, `mem_req`=0. Stays until reset.
- Latency in cycles, assuming `mem_ready`=1 on first request:
  - R-type, I-ALU, lui, auipc: 4
  - branch: 3
  - jal: 4
  - jalr: 5
  - load: 5
  - store: 4
  - Each wait cycle adds 1.
- `ALUControl` comes from the ALU decoder fed with ALUOp, `funct3`, `funct7b5` and `op[5]`. For I-type, `funct7b5` is ignored except for srai.
- `mem_ready` asserted while `mem_req`=0 is ignored.
- Reset asserted mid-access (including during a stall) aborts immediately. No strobe is issued in that cycle.

Decomposition:
- Package `mc_pkg`:
  - state encoding localparams S_FETCH=0 … S_TRAP=15 (4 bits)
  - opcode constants: OP_LOAD=0000011, OP_STORE=0100011, OP_R=0110011, OP_I=0010011, OP_BR=1100011, OP_JAL=1101111, OP_JALR=1100111, OP_LUI=0110111, OP_AUIPC=0010111
  - ALUOp and ImmSrc codes
- Sub-module: the existing `aludec`, instantiated unchanged. The FSM and branch-condition logic stay in `mc_controller`.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with `mem_ready`=1 -> state sequence 0,1,6,8,0. `RegWrite`=1 only in cycle 4; `ALUControl` = add in S_EXECR.
- lw (0x0000A183) with `mem_ready` low for 2 cycles in S_MEMREAD -> `mem_req`=1 and `AdrSrc`=1 held for 3 cycles. S_MEMWB follows with `ResultSrc`=01 and `RegWrite`=1.
- Branch funct3=001 (bne) with zero=0 -> `PCWrite`=1 in S_BRANCH. Same instruction with zero=1 -> `PCWrite`=0. Both return to S_FETCH after 3 cycles.
- jalr (0x000080E7) -> states 0,1,S_JALR,S_JALRPC,S_ALUWB. `PCWrite` high in S_JALRPC, `RegWrite` high in S_ALUWB.
- op=0000000 -> `illegal_instr`=1 and state 15 held for 10+ cycles with no strobes. `rst_n` pulse -> S_FETCH and `illegal_instr`=0.
- `rst_n` asserted during a S_MEMWRITE stall -> `MemWrite` never pulses. After release, state=S_FETCH and `mem_req`=1.
